// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the CPU datapath (slave).
// The controller drives every strobe; the datapath returns IR fields, ALU flags and mem_ready.
interface multicycle_ctrl_if #(
  parameter int ALU_W = 3
);
  logic [5:0]       OP;
  logic [5:0]       FUNCT;
  logic             zero;
  logic             overflow;
  logic             mem_ready;

  logic             PCWr;
  logic [1:0]       PCsrc;
  logic             IorD;
  logic             MemRd;
  logic             MemWr;
  logic             IRWr;
  logic             RegWr;
  logic [1:0]       RegDst;
  logic [1:0]       MemToReg;
  logic             ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [ALU_W-1:0] ALUctrl;
  logic             trap;
  logic [2:0]       state;

  // Memory handshake: MemRd/MemWr is a request held high until the cycle in which
  // mem_ready is also high; that cycle completes the transfer. mem_ready is ignored
  // whenever no request is outstanding.
  modport master (
    input  OP, FUNCT, zero, overflow, mem_ready,
    output PCWr, PCsrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemToReg,
           ALUsrcA, ALUsrcB, ALUctrl, trap, state
  );

  modport slave (
    output OP, FUNCT, zero, overflow, mem_ready,
    input  PCWr, PCsrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemToReg,
           ALUsrcA, ALUsrcB, ALUctrl, trap, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and
// memory port, with a sticky TRAP for illegal opcodes, arithmetic overflow and memory timeout.
module multicycle_ctrl #(
  parameter int ALU_W       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t           stateQ;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;

  logic isRtype;
  logic isJr;
  logic isRArith;
  logic isAddi;
  logic isXori;
  logic isLw;
  logic isSw;
  logic isBeq;
  logic isBne;
  logic ovfChecked;
  logic timeoutHit;

  assign isRtype    = (bus.OP == OP_RTYPE);
  assign isJr       = isRtype && (bus.FUNCT == FN_JR);
  assign isRArith   = isRtype && ((bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB) ||
                                  (bus.FUNCT == FN_SLT));
  assign isAddi     = (bus.OP == OP_ADDI);
  assign isXori     = (bus.OP == OP_XORI);
  assign isLw       = (bus.OP == OP_LW);
  assign isSw       = (bus.OP == OP_SW);
  assign isBeq      = (bus.OP == OP_BEQ);
  assign isBne      = (bus.OP == OP_BNE);
  // SLT and XORI cannot overflow architecturally, so their flag is ignored.
  assign ovfChecked = isAddi ||
                      (isRtype && ((bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB)));
  // waitCnt holds the number of earlier wait cycles; this cycle would be the last allowed.
  assign timeoutHit = (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

  assign bus.state = stateQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= FETCH;
      waitCnt <= '0;
    end else begin
      stateQ  <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    waitCntNext = '0;
    if ((stateNext == stateQ) && ((stateQ == FETCH) || (stateQ == MEM)) && !bus.mem_ready) begin
      waitCntNext = waitCnt + 1'b1;
    end
  end

  always_comb begin
    stateNext    = stateQ;
    bus.PCWr     = 1'b0;
    bus.PCsrc    = 2'd0;
    bus.IorD     = 1'b0;
    bus.MemRd    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.IRWr     = 1'b0;
    bus.RegWr    = 1'b0;
    bus.RegDst   = 2'd0;
    bus.MemToReg = 2'd0;
    bus.ALUsrcA  = 1'b0;
    bus.ALUsrcB  = 2'd0;
    bus.ALUctrl  = ALU_ADD;
    bus.trap     = 1'b0;

    case (stateQ)
      FETCH: begin
        bus.MemRd   = 1'b1;
        bus.IorD    = 1'b0;
        bus.ALUsrcA = 1'b0;
        bus.ALUsrcB = 2'd1;
        bus.ALUctrl = ALU_ADD;
        if (bus.mem_ready) begin
          bus.IRWr  = 1'b1;
          bus.PCWr  = 1'b1;
          bus.PCsrc = 2'd0;
          stateNext = DECODE;
        end else if (timeoutHit) begin
          stateNext = TRAP;
        end
      end

      DECODE: begin
        // ALU computes PC + sext(imm)<<2 so ALUOut holds the branch target for EXEC.
        bus.ALUsrcA = 1'b0;
        bus.ALUsrcB = 2'd3;
        bus.ALUctrl = ALU_ADD;
        if (bus.OP == OP_J) begin
          bus.PCWr  = 1'b1;
          bus.PCsrc = 2'd2;
          stateNext = FETCH;
        end else if (bus.OP == OP_JAL) begin
          bus.PCWr     = 1'b1;
          bus.PCsrc    = 2'd2;
          bus.RegWr    = 1'b1;
          bus.RegDst   = 2'd2;
          bus.MemToReg = 2'd2;
          stateNext    = FETCH;
        end else if (isJr) begin
          bus.PCWr  = 1'b1;
          bus.PCsrc = 2'd3;
          stateNext = FETCH;
        end else if (isRArith || isAddi || isXori || isLw || isSw || isBeq || isBne) begin
          stateNext = EXEC;
        end else begin
          stateNext = TRAP;
        end
      end

      EXEC: begin
        bus.ALUsrcA = 1'b1;
        if (isRArith) begin
          bus.ALUsrcB = 2'd0;
          case (bus.FUNCT)
            FN_SUB:  bus.ALUctrl = ALU_SUB;
            FN_SLT:  bus.ALUctrl = ALU_SLT;
            default: bus.ALUctrl = ALU_ADD;
          endcase
          stateNext = (ovfChecked && bus.overflow) ? TRAP : WB;
        end else if (isAddi) begin
          bus.ALUsrcB = 2'd2;
          bus.ALUctrl = ALU_ADD;
          stateNext   = bus.overflow ? TRAP : WB;
        end else if (isXori) begin
          bus.ALUsrcB = 2'd2;
          bus.ALUctrl = ALU_XOR;
          stateNext   = WB;
        end else if (isLw || isSw) begin
          bus.ALUsrcB = 2'd2;
          bus.ALUctrl = ALU_ADD;
          stateNext   = MEM;
        end else if (isBeq || isBne) begin
          bus.ALUsrcB = 2'd0;
          bus.ALUctrl = ALU_SUB;
          bus.PCsrc   = 2'd1;
          bus.PCWr    = isBeq ? bus.zero : !bus.zero;
          stateNext   = FETCH;
        end else begin
          stateNext = TRAP;
        end
      end

      MEM: begin
        bus.IorD  = 1'b1;
        bus.MemRd = isLw;
        bus.MemWr = isSw;
        if (!(isLw || isSw)) begin
          stateNext = TRAP;
        end else if (bus.mem_ready) begin
          stateNext = isLw ? WB : FETCH;
        end else if (timeoutHit) begin
          stateNext = TRAP;
        end
      end

      WB: begin
        bus.RegWr    = 1'b1;
        bus.RegDst   = isRtype ? 2'd1 : 2'd0;
        bus.MemToReg = isLw ? 2'd1 : 2'd0;
        stateNext    = FETCH;
      end

      TRAP: begin
        bus.trap = 1'b1;
      end

      default: begin
        stateNext = TRAP;
      end
    endcase

    // Reset squashes every side effect in the cycle it is seen, including a held MemWr.
    if (reset) begin
      bus.PCWr     = 1'b0;
      bus.PCsrc    = 2'd0;
      bus.IorD     = 1'b0;
      bus.MemRd    = 1'b0;
      bus.MemWr    = 1'b0;
      bus.IRWr     = 1'b0;
      bus.RegWr    = 1'b0;
      bus.RegDst   = 2'd0;
      bus.MemToReg = 2'd0;
      bus.ALUsrcA  = 1'b0;
      bus.ALUsrcB  = 2'd0;
      bus.ALUctrl  = ALU_ADD;
      bus.trap     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model predicts the control word of every
// cycle into a queue; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irwr;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic       trp;
  } ctrl_t;

  typedef enum {K_J, K_JAL, K_JR, K_RARITH, K_ADDI, K_XORI, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_t;

  logic clk = 1'b0;
  logic reset;
  logic [21:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALU_W(3)) bus();

  multicycle_ctrl #(.ALU_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic ctrl_t dut_word();
    ctrl_t g;
    g.st       = bus.state;
    g.pcwr     = bus.PCWr;
    g.pcsrc    = bus.PCsrc;
    g.iord     = bus.IorD;
    g.memrd    = bus.MemRd;
    g.memwr    = bus.MemWr;
    g.irwr     = bus.IRWr;
    g.regwr    = bus.RegWr;
    g.regdst   = bus.RegDst;
    g.memtoreg = bus.MemToReg;
    g.srca     = bus.ALUsrcA;
    g.srcb     = bus.ALUsrcB;
    g.aluc     = bus.ALUctrl;
    g.trp      = bus.trap;
    return g;
  endfunction

  // Monitor: compares whatever the DUT shows mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    ctrl_t e;
    ctrl_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = dut_word();
      n_vec++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL ctrl_word cyc=%0d got=%h (state=%0d) expected=%h (state=%0d)",
                 cyc, g, g.st, e, e.st);
      end
    end
  end

  // Driver: one clock cycle with given inputs and the control word predicted for it.
  task automatic step(input ctrl_t w, input logic mr, input logic rst);
    reset         = rst;
    bus.mem_ready = mr;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00: begin
        if (funct == 6'h08) return K_JR;
        if (funct == 6'h20 || funct == 6'h22 || funct == 6'h2a) return K_RARITH;
        return K_ILL;
      end
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h08:   return K_ADDI;
      6'h0e:   return K_XORI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  // Sticky trap for a few cycles (mem_ready wiggling is ignored), then a reset cycle.
  task automatic trap_then_reset();
    ctrl_t w;
    w = '0;
    w.st  = 3'd7;
    w.trp = 1'b1;
    repeat (2 + $urandom_range(0, 2)) step(w, rnd_bit(), 1'b0);
    w = '0;
    w.st = 3'd7;
    step(w, rnd_bit(), 1'b1);
  endtask

  // A memory access (instruction fetch or data access) waiting 'waits' cycles for mem_ready.
  task automatic mem_phase(input bit is_fetch, input bit wr, input int waits, output bit timed_out);
    ctrl_t w;
    timed_out = 1'b0;
    w = '0;
    if (is_fetch) begin
      w.st    = 3'd0;
      w.memrd = 1'b1;
      w.srcb  = 2'd1;
    end else begin
      w.st    = 3'd3;
      w.iord  = 1'b1;
      w.memrd = !wr;
      w.memwr = wr;
    end
    for (int i = 0; i < waits; i++) begin
      step(w, 1'b0, 1'b0);
      if (i == MEM_TIMEOUT - 1) begin
        timed_out = 1'b1;
        return;
      end
    end
    if (is_fetch) begin
      w.irwr = 1'b1;
      w.pcwr = 1'b1;
    end
    step(w, 1'b1, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                           input logic ov, input int fw, input int mw, input bit rst_mem);
    kind_t k;
    ctrl_t w;
    bit    to;
    int    nw;
    k = classify(op, funct);
    bus.OP       = op;
    bus.FUNCT    = funct;
    bus.zero     = z;
    bus.overflow = ov;

    mem_phase(1'b1, 1'b0, fw, to);
    if (to) begin
      trap_then_reset();
      return;
    end

    w = '0;
    w.st   = 3'd1;
    w.srcb = 2'd3;
    if (k == K_J)  begin w.pcwr = 1'b1; w.pcsrc = 2'd2; end
    if (k == K_JR) begin w.pcwr = 1'b1; w.pcsrc = 2'd3; end
    if (k == K_JAL) begin
      w.pcwr = 1'b1; w.pcsrc = 2'd2; w.regwr = 1'b1; w.regdst = 2'd2; w.memtoreg = 2'd2;
    end
    step(w, rnd_bit(), 1'b0);
    if (k == K_J || k == K_JAL || k == K_JR) return;
    if (k == K_ILL) begin
      trap_then_reset();
      return;
    end

    w = '0;
    w.st   = 3'd2;
    w.srca = 1'b1;
    case (k)
      K_RARITH: w.aluc = (funct == 6'h22) ? 3'd1 : (funct == 6'h2a) ? 3'd3 : 3'd0;
      K_ADDI, K_LW, K_SW: w.srcb = 2'd2;
      K_XORI: begin w.srcb = 2'd2; w.aluc = 3'd2; end
      K_BEQ, K_BNE: begin
        w.aluc  = 3'd1;
        w.pcsrc = 2'd1;
        w.pcwr  = (k == K_BEQ) ? z : !z;
      end
      default: ;
    endcase
    step(w, rnd_bit(), 1'b0);
    if (k == K_BEQ || k == K_BNE) return;
    if (ov && (k == K_ADDI || (k == K_RARITH && funct != 6'h2a))) begin
      trap_then_reset();
      return;
    end

    if (k == K_LW || k == K_SW) begin
      if (rst_mem) begin
        nw = $urandom_range(0, 2);
        w = '0;
        w.st    = 3'd3;
        w.iord  = 1'b1;
        w.memrd = (k == K_LW);
        w.memwr = (k == K_SW);
        repeat (nw) step(w, 1'b0, 1'b0);
        w = '0;
        w.st = 3'd3;
        step(w, 1'b0, 1'b1);
        return;
      end
      mem_phase(1'b0, k == K_SW, mw, to);
      if (to) begin
        trap_then_reset();
        return;
      end
      if (k == K_SW) return;
    end

    w = '0;
    w.st       = 3'd4;
    w.regwr    = 1'b1;
    w.regdst   = (k == K_RARITH) ? 2'd1 : 2'd0;
    w.memtoreg = (k == K_LW) ? 2'd1 : 2'd0;
    step(w, rnd_bit(), 1'b0);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 19) == 0) return $urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 3);
    return $urandom_range(0, 3);
  endfunction

  task automatic run_random(input int count);
    logic [5:0] ops [10];
    logic [5:0] fns [5];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b, 6'h00};
    fns = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00};
    for (int n = 0; n < count; n++) begin
      if ($urandom_range(0, 11) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 9)];
      if (op == 6'h00) begin
        fn = fns[$urandom_range(0, 4)];
        if (fn == 6'h00) fn = 6'($urandom_range(0, 63));
      end else begin
        fn = 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, rnd_bit(), rnd_bit(), pick_wait(), pick_wait(),
                $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    ctrl_t w;
    reset         = 1'b1;
    bus.OP        = 6'h00;
    bus.FUNCT     = 6'h00;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    w = '0;
    step(w, 1'b1, 1'b1);

    run_instr(6'h23, 6'h11, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0, 2, 0, 1'b0);
    run_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0, 3, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0, 40, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 40, 0, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 14, 14, 1'b0);
    run_instr(6'h3f, 6'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(6'h00, 6'h2a, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(6'h0e, 6'h00, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0, 1'b0);

    run_random(80);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain left=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
